// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, requests one word at a time from instruction
// memory, holds it in an instruction register and hands it downstream via valid/ready.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        ivalid,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_WAIT - 1);
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StErr} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= Nop;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (ivalid) begin
          instr_d = idata;
          cnt_d   = '0;
          state_d = StIssue;
        end else if (cnt_q == LastCnt) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIssue: begin
        if (instr_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = StFetch;
        end
      end
      StErr: ;
      default: state_d = StErr;
    endcase

    // Redirect wins over anything decided above, including a same-cycle fetch or timeout.
    if (redirect && state_q != StErr) begin
      instr_d = instr_q;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d    = redirect_pc;
        cnt_d   = '0;
        err_d   = err_q;
        state_d = StFetch;
      end else begin
        pc_d    = pc_q;
        err_d   = 1'b1;
        state_d = StErr;
      end
    end
  end

  assign ireq        = (state_q == StFetch);
  assign instr_valid = (state_q == StIssue);
  assign iaddr       = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios, then random memory latency / consumer
// back-pressure / redirects checked through an issue scoreboard.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq, ivalid, instr_valid, instr_ready, redirect, fetch_err;
  logic [31:0] iaddr, idata, pc, instr, redirect_pc;

  logic        reset2, ireq2, valid2, err2;
  logic [31:0] iaddr2, pc2, instr2;

  always #5 clk = ~clk;

  ifetch_ctrl #(.RESET_PC(32'h0000_0000), .MAX_WAIT(16)) dut (
    .clk(clk), .reset(reset), .ireq(ireq), .iaddr(iaddr), .idata(idata), .ivalid(ivalid),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  // Second instance: zero-latency memory, always-ready consumer, PC at the top of memory.
  ifetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(16)) dut_wrap (
    .clk(clk), .reset(reset2), .ireq(ireq2), .iaddr(iaddr2), .idata(32'h0000_0013),
    .ivalid(ireq2), .pc(pc2), .instr(instr2), .instr_valid(valid2), .instr_ready(1'b1),
    .redirect(1'b0), .redirect_pc(32'h0), .fetch_err(err2)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   hs = 0;
  int   stall = 0;
  logic sb_en = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard monitor: every accepted issue must match the oldest expected (pc, instr).
  always @(negedge clk) begin
    if (sb_en) begin
      #1;
      if (instr_valid && instr_ready && !redirect) begin
        hs++;
        stall = 0;
        if (sbq.size() == 0) begin
          check("sb_unexpected_issue", {32'h0, pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_issue", {pc, instr}, {e.pc, e.ins});
        end
      end else begin
        stall++;
        if (stall == 200) check("sb_progress_timeout", 64'(stall), 64'd0);
      end
    end
  end

  initial begin
    int          cnt, mw;
    logic [31:0] nxt_pc, a2, pc_seen;
    logic        seen, got;

    reset = 1'b1; reset2 = 1'b1;
    ivalid = 1'b0; idata = '0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #3;
    check("rst_ireq", 64'(ireq), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_instr", 64'(instr), 64'h13);
    check("rst_err", 64'(fetch_err), 64'd0);

    // Zero-latency fetch, ready consumer
    @(negedge clk); reset = 1'b0;
    check("t1_idle_ireq", 64'(ireq), 64'd0);
    step();
    check("t1_fetch", {31'h0, ireq, iaddr}, {31'h0, 1'b1, 32'h0});
    ivalid = 1'b1; idata = 32'h0050_0093; instr_ready = 1'b1;
    step(); ivalid = 1'b0;
    check("t1_issue", {instr_valid, instr, pc}, {1'b1, 32'h0050_0093, 32'h0});
    step();
    check("t1_next_fetch", {31'h0, ireq, iaddr}, {31'h0, 1'b1, 32'h4});

    // Back-pressure hold
    ivalid = 1'b1; idata = 32'h1111_2222; instr_ready = 1'b0;
    step(); ivalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold", {instr_valid, ireq, pc, instr}, {1'b1, 1'b0, 32'h4, 32'h1111_2222});
      step();
    end
    instr_ready = 1'b1;
    step(); instr_ready = 1'b0;
    check("t2_after_ready", {31'h0, ireq, iaddr}, {31'h0, 1'b1, 32'h8});

    // Redirect beats ready in ISSUE; redirect discards same-cycle ivalid in FETCH
    ivalid = 1'b1; idata = 32'h3333_4444;
    step(); ivalid = 1'b0;
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    step(); redirect = 1'b0; instr_ready = 1'b0;
    check("t3_redirect_issue", {31'h0, ireq, iaddr}, {31'h0, 1'b1, 32'h100});
    ivalid = 1'b1; idata = 32'hDEAD_BEEF; redirect = 1'b1; redirect_pc = 32'h200;
    step(); ivalid = 1'b0; redirect = 1'b0;
    check("t3_redirect_fetch", {ireq, instr_valid, iaddr, instr},
          {1'b1, 1'b0, 32'h200, 32'h3333_4444});

    // Timeout after MAX_WAIT request cycles
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ireq) break;
      cnt++;
      step();
    end
    check("t4_timeout_cycles", 64'(cnt), 64'd16);
    check("t4_err", {62'h0, fetch_err, ireq}, {62'h0, 1'b1, 1'b0});
    ivalid = 1'b1; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    repeat (4) step();
    ivalid = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    check("t4_err_sticky", {61'h0, fetch_err, ireq, instr_valid}, {61'h0, 3'b100});

    // Misaligned redirect
    reset = 1'b1; step(); reset = 1'b0;
    check("t4b_err_cleared", 64'(fetch_err), 64'd0);
    redirect = 1'b1; redirect_pc = 32'h102;
    step(); redirect = 1'b0;
    check("t4b_misaligned", {61'h0, fetch_err, ireq, instr_valid}, {61'h0, 3'b100});
    repeat (3) step();
    check("t4b_sticky", {61'h0, fetch_err, ireq, instr_valid}, {61'h0, 3'b100});

    // Asynchronous reset in the middle of a fetch
    reset = 1'b1; step(); reset = 1'b0;
    step();
    ivalid = 1'b1; idata = 32'h0A0B_0C0D; instr_ready = 1'b1;
    step(); ivalid = 1'b0;
    step(); instr_ready = 1'b0;
    check("t6_pre", {ireq, iaddr, instr}, {1'b1, 32'h4, 32'h0A0B_0C0D});
    #2 reset = 1'b1;
    #1;
    check("t6_async", {ireq, instr_valid, pc, instr}, {2'b00, 32'h0, 32'h13});

    // Random phase
    step();
    sbq.delete();
    nxt_pc = 32'h0;
    sbq.push_back('{pc: nxt_pc, ins: mem(nxt_pc)});
    mw = 0;
    reset = 1'b0; sb_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (ireq) begin
        ivalid = (mw >= 4) || ($urandom_range(0, 2) == 0);
        idata  = ivalid ? mem(iaddr) : $urandom;
        mw     = ivalid ? 0 : mw + 1;
      end else begin
        ivalid = 1'b0; idata = $urandom; mw = 0;
      end
      instr_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      if (redirect) begin
        sbq.delete();
        nxt_pc = redirect_pc;
        sbq.push_back('{pc: nxt_pc, ins: mem(nxt_pc)});
        mw = 0;
      end else if (instr_valid && instr_ready) begin
        nxt_pc = nxt_pc + 32'd4;
        sbq.push_back('{pc: nxt_pc, ins: mem(nxt_pc)});
      end
      step();
    end
    instr_ready = 1'b0; redirect = 1'b0; ivalid = 1'b0;
    #2 sb_en = 1'b0;
    check("sb_activity", 64'(hs >= 300), 64'd1);
    check("sb_no_err", 64'(fetch_err), 64'd0);

    // PC wrap from the top of the address space
    @(negedge clk); reset2 = 1'b0;
    seen = 1'b0; got = 1'b0; pc_seen = '0; a2 = '1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid2 && !seen) begin
        seen = 1'b1; pc_seen = pc2;
      end else if (seen && ireq2) begin
        got = 1'b1; a2 = iaddr2;
        break;
      end
    end
    check("t5_seen", {62'h0, seen, got}, {62'h0, 2'b11});
    check("t5_first_pc", 64'(pc_seen), 64'hFFFF_FFFC);
    check("t5_wrap_iaddr", 64'(a2), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
